// File: rtl/ttpu_pkg.sv
// Shared TTPU types: fp16 container, MAC sequencer FSM states and fp16 constants.
package ttpu_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL,
    ADD,
    DONE
  } mac_seq_state_t;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;

endpackage

// File: rtl/lat_timer.sv
// Load/clear down-counter with terminal-count flag; times fixed-latency unit waits.
module lat_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: pulls operand pairs, times the external fp16 multiplier
// and adder by their fixed latencies, and returns the accumulated sum.
module mac_sequencer
  import ttpu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned ADD_LAT = 4,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mul_en,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [15:0]      mul_result,
  output logic             add_en,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  mac_seq_state_t   state, state_next;
  fp16_t            acc, prod;
  logic [LEN_W-1:0] remaining;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;

  // Reloading on the state-entry edge makes the timer expire on the
  // LAT-th cycle spent in MUL/ADD, matching an up-count to LAT-1.
  lat_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       ((state == MUL) || (state == ADD)),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    job_ready  = 1'b0;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    mul_en     = 1'b0;
    add_en     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          state_next = (job_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_next = MUL;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(MUL_LAT - 1);
        end
      end
      MUL: begin
        mul_en = 1'b1;
        if (tmr_tc) begin
          state_next = ADD;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(ADD_LAT - 1);
        end
      end
      ADD: begin
        add_en = 1'b1;
        if (tmr_tc) begin
          state_next = (remaining == LEN_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= FP16_ZERO;
      prod      <= FP16_ZERO;
      mul_a     <= FP16_ZERO;
      mul_b     <= FP16_ZERO;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (job_valid) begin
            acc       <= FP16_ZERO;
            remaining <= job_len;
          end
        end
        FETCH: begin
          if (op_valid) begin
            mul_a <= op_a;
            mul_b <= op_b;
          end
        end
        MUL: begin
          if (tmr_tc) begin
            prod <= mul_result;
          end
        end
        ADD: begin
          if (tmr_tc) begin
            acc       <= add_result;
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign add_a    = prod;
  assign add_b    = acc;
  assign res_data = acc;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with behavioural fixed-latency fp16 mul/add units.
module tb_mac_sequencer;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned ADD_LAT = 4;
  localparam int unsigned LEN_W   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [LEN_W-1:0] job_len = '0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [15:0]      op_a = '0;
  logic [15:0]      op_b = '0;
  logic             mul_en;
  logic [15:0]      mul_a, mul_b, mul_result;
  logic             add_en;
  logic [15:0]      add_a, add_b, add_result;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [15:0]      res_data;
  logic             busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] pa [256];
  logic [15:0] pb [256];

  mac_sequencer #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_len    (job_len),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .mul_en     (mul_en),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .add_en     (add_en),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // fp16 reference arithmetic through real values (normals and zero).
  function automatic real h2r(input logic [15:0] h);
    real m, v;
    int  e;
    e = int'(h[14:10]);
    m = real'(h[9:0]) / 1024.0;
    if (e == 0) v = m * (2.0 ** real'(-14));
    else        v = (1.0 + m) * (2.0 ** real'(e - 15));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  a;
    int   e, m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    for (int i = 0; i < 64 && a >= 2.0; i++) begin a = a / 2.0; e++; end
    for (int i = 0; i < 64 && a < 1.0; i++)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0)  return {s, 15'h0000};
    return {s, 5'(e), 10'(m)};
  endfunction

  // Multiplier: result valid at the MUL_LAT-th edge; adder at the ADD_LAT-th.
  logic [15:0] mul_q;
  logic [15:0] add_q [3];
  always @(posedge clk) begin
    if (reset) begin
      mul_q    <= '0;
      add_q[0] <= '0;
      add_q[1] <= '0;
      add_q[2] <= '0;
    end else begin
      mul_q    <= r2h(h2r(mul_a) * h2r(mul_b));
      add_q[0] <= r2h(h2r(add_a) + h2r(add_b));
      add_q[1] <= add_q[0];
      add_q[2] <= add_q[1];
    end
  end
  assign mul_result = mul_q;
  assign add_result = add_q[2];

  // Runs one job from IDLE; t counts edges after the job handshake edge.
  task automatic run_job(input int len, input int stall_idx, input int stall_cycles,
                         input int hold, input int limit,
                         output int rise, output logic [15:0] data,
                         output int mul_cnt, output int add_cnt, output int overlap,
                         output int ops, output int unstable, output int jr_bad,
                         output int busy_bad, output logic jr_after, output int timeout);
    int t, idx, stall_left, held, done;
    logic hs_op, hs_res;
    rise = -1; data = '0; mul_cnt = 0; add_cnt = 0; overlap = 0; ops = 0;
    unstable = 0; jr_bad = 0; busy_bad = 0; idx = 0; held = 0; done = 0;
    stall_left = stall_cycles;
    job_valid = 1'b1;
    job_len   = LEN_W'(len);
    res_ready = 1'b0;
    @(posedge clk); #1;
    job_valid = 1'b0;
    t = 0;
    while (!done && t < limit) begin
      if (res_valid && rise < 0) begin rise = t; data = res_data; end
      if (res_valid && res_data !== data) unstable++;
      if (job_ready) jr_bad++;
      if (!busy) busy_bad++;
      if (op_ready && idx == stall_idx && stall_left > 0) begin
        op_valid = 1'b0;
        stall_left--;
      end else begin
        op_valid = (idx < len);
        op_a = pa[idx[7:0]];
        op_b = pb[idx[7:0]];
      end
      res_ready = (rise >= 0 && held >= hold);
      if (rise >= 0 && !res_ready) held++;
      if (mul_en) mul_cnt++;
      if (add_en) add_cnt++;
      if (mul_en && add_en) overlap++;
      hs_op  = op_valid && op_ready;
      hs_res = res_valid && res_ready;
      @(posedge clk); #1;
      t++;
      if (hs_op) begin idx++; ops++; end
      if (hs_res) done = 1;
    end
    op_valid  = 1'b0;
    res_ready = 1'b0;
    jr_after  = job_ready;
    timeout   = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got jr=%b busy=%b opr=%b rv=%b want 1 0 0 0",
               job_ready, busy, op_ready, res_valid);
    end
    checks++;
    if ({mul_en, add_en} !== 2'b00 || mul_a !== 16'h0 || mul_b !== 16'h0 ||
        add_a !== 16'h0 || add_b !== 16'h0 || res_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got me=%b ae=%b ma=%h mb=%h aa=%h ab=%h rd=%h want all 0",
               mul_en, add_en, mul_a, mul_b, add_a, add_b, res_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_len0();
    int rise, mc, ac, ov, ops, us, jb, bb, to;
    logic [15:0] d;
    logic ja;
    run_job(0, -1, 0, 0, 20, rise, d, mc, ac, ov, ops, us, jb, bb, ja, to);
    checks++;
    if (to != 0 || rise != 0) begin errors++; $display("FAIL len0_latency: got rise=%0d timeout=%0d want 0 0", rise, to); end
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL len0_data: got %h want 0000", d); end
    checks++;
    if (mc != 0 || ac != 0 || ops != 0) begin errors++; $display("FAIL len0_enables: got mul=%0d add=%0d ops=%0d want 0 0 0", mc, ac, ops); end
  endtask

  task automatic test_len1();
    int rise, mc, ac, ov, ops, us, jb, bb, to;
    logic [15:0] d;
    logic ja;
    pa[0] = 16'h4000; pb[0] = 16'h4200;
    run_job(1, -1, 0, 0, 50, rise, d, mc, ac, ov, ops, us, jb, bb, ja, to);
    checks++;
    if (to != 0 || rise != 7) begin errors++; $display("FAIL len1_latency: got rise=%0d timeout=%0d want 7 0", rise, to); end
    checks++;
    if (d !== 16'h4600) begin errors++; $display("FAIL len1_data: got %h want 4600", d); end
    checks++;
    if (mc != 2 || ac != 4 || ov != 0) begin errors++; $display("FAIL len1_enables: got mul=%0d add=%0d overlap=%0d want 2 4 0", mc, ac, ov); end
    checks++;
    if (bb != 0 || jb != 0 || ja !== 1'b1) begin errors++; $display("FAIL len1_busy: got busy_low=%0d jr_busy=%0d jr_after=%b want 0 0 1", bb, jb, ja); end
  endtask

  task automatic test_len2();
    int rise, mc, ac, ov, ops, us, jb, bb, to;
    logic [15:0] d;
    logic ja;
    pa[0] = 16'h3C00; pb[0] = 16'h4000;
    pa[1] = 16'h4200; pb[1] = 16'h4000;
    run_job(2, -1, 0, 0, 60, rise, d, mc, ac, ov, ops, us, jb, bb, ja, to);
    checks++;
    if (to != 0 || rise != 14) begin errors++; $display("FAIL len2_latency: got rise=%0d timeout=%0d want 14 0", rise, to); end
    checks++;
    if (d !== 16'h4800) begin errors++; $display("FAIL len2_data: got %h want 4800", d); end
    checks++;
    if (mc != 4 || ac != 8 || ov != 0 || ops != 2) begin errors++; $display("FAIL len2_enables: got mul=%0d add=%0d overlap=%0d ops=%0d want 4 8 0 2", mc, ac, ov, ops); end
  endtask

  task automatic test_stall();
    int rise, mc, ac, ov, ops, us, jb, bb, to;
    logic [15:0] d;
    logic ja;
    pa[0] = 16'h3C00; pb[0] = 16'h4000;
    pa[1] = 16'h4200; pb[1] = 16'h4000;
    run_job(2, 1, 3, 5, 80, rise, d, mc, ac, ov, ops, us, jb, bb, ja, to);
    checks++;
    if (to != 0 || rise != 17) begin errors++; $display("FAIL stall_latency: got rise=%0d timeout=%0d want 17 0", rise, to); end
    checks++;
    if (d !== 16'h4800) begin errors++; $display("FAIL stall_data: got %h want 4800", d); end
    checks++;
    if (us != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", us); end
    checks++;
    if (jb != 0 || ja !== 1'b1) begin errors++; $display("FAIL stall_job_ready: got early=%0d after=%b want 0 1", jb, ja); end
  endtask

  task automatic test_reset_mid();
    int rise, mc, ac, ov, ops, us, jb, bb, to, n;
    logic [15:0] d;
    logic ja;
    job_valid = 1'b1;
    job_len   = LEN_W'(2);
    @(posedge clk); #1;
    job_valid = 1'b0;
    op_valid  = 1'b1; op_a = 16'h3C00; op_b = 16'h4000;
    n = 0;
    while (!add_en && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (add_en !== 1'b1) begin errors++; $display("FAIL mid_reach_add: got add_en=%b want 1", add_en); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    op_valid = 1'b0;
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0 ||
        mul_en !== 1'b0 || add_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got jr=%b busy=%b opr=%b rv=%b me=%b ae=%b want 1 0 0 0 0 0",
               job_ready, busy, op_ready, res_valid, mul_en, add_en);
    end
    checks++;
    if (mul_a !== 16'h0 || mul_b !== 16'h0 || add_a !== 16'h0 || add_b !== 16'h0 || res_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_data: got ma=%h mb=%h aa=%h ab=%h rd=%h want all 0",
               mul_a, mul_b, add_a, add_b, res_data);
    end
    pa[0] = 16'h3800; pb[0] = 16'h4400;
    run_job(1, -1, 0, 0, 50, rise, d, mc, ac, ov, ops, us, jb, bb, ja, to);
    checks++;
    if (to != 0 || rise != 7 || d !== 16'h4000) begin
      errors++;
      $display("FAIL mid_followup: got rise=%0d data=%h timeout=%0d want 7 4000 0", rise, d, to);
    end
  endtask

  task automatic test_len255();
    int rise, mc, ac, ov, ops, us, jb, bb, to;
    logic [15:0] d;
    logic ja;
    for (int i = 0; i < 256; i++) begin pa[i] = 16'h3C00; pb[i] = 16'h3C00; end
    run_job(255, -1, 0, 0, 2500, rise, d, mc, ac, ov, ops, us, jb, bb, ja, to);
    checks++;
    if (ops != 255) begin errors++; $display("FAIL len255_ops: got %0d want 255", ops); end
    checks++;
    if (to != 0 || rise != 1785) begin errors++; $display("FAIL len255_latency: got rise=%0d timeout=%0d want 1785 0", rise, to); end
    checks++;
    if (d !== 16'h5BF8) begin errors++; $display("FAIL len255_data: got %h want 5bf8", d); end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_len1();
    test_len2();
    test_stall();
    test_reset_mid();
    test_len255();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
